// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/freeze controller.
// Holds the FSM state type, the pipeline-control bundle and register-match helper.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // Instruction word the IF/ID register takes on IF_ID_flush (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Front-end controls that always move together for a given pipeline action.
  typedef struct packed {
    logic if_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic ctrl_clear;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN   = '{if_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1, ctrl_clear: 1'b0};
  localparam pipe_ctl_t CTL_HOLD  = '{if_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0, ctrl_clear: 1'b0};
  localparam pipe_ctl_t CTL_FLUSH = '{if_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1, ctrl_clear: 1'b1};
  localparam pipe_ctl_t CTL_STALL = '{if_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1, ctrl_clear: 1'b1};

  // $zero is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_hit(input logic [4:0] dest, input logic [4:0] src);
    return (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at LIMIT; used for the wait timer and perf counters.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and freeze controller for the 5-stage MIPS core: load-use stalls,
// taken-branch flushes, data-memory wait freeze, wait timeout and perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [4:0]       ID_src1,
  input  logic [4:0]       ID_src2,
  input  logic             ID_two_src,
  input  logic [4:0]       EXE_dest,
  input  logic             EXE_MEM_R_en,
  input  logic             EXE_WB_en,
  input  logic             EXE_Br_taken,
  input  logic [4:0]       MEM_dest,
  input  logic             MEM_WB_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             IF_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ctrl_clear,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  pipe_ctl_t         ctl;
  logic              mem_busy;
  logic              hit_exe;
  logic              hit_mem;
  logic              raw_hazard;
  logic              stall_ev;
  logic              flush_ev;
  logic              wait_entry;
  logic              wait_inc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  // Dependency detection on the ID-stage sources.
  always_comb begin
    hit_exe    = reg_hit(EXE_dest, ID_src1) | (ID_two_src & reg_hit(EXE_dest, ID_src2));
    hit_mem    = reg_hit(MEM_dest, ID_src1) | (ID_two_src & reg_hit(MEM_dest, ID_src2));
    raw_hazard = ID_valid & ((EXE_MEM_R_en & hit_exe) |
                             (~FWD_EN & ((EXE_WB_en & hit_exe) | (MEM_WB_en & hit_mem))));
  end

  // The request cycle itself already freezes, so a wait of N not-ready cycles
  // costs exactly N frozen cycles.
  always_comb begin
    mem_busy = (state == MEM_WAIT) ? ~mem_ready : (mem_req & ~mem_ready);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ctl      = CTL_RUN;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (mem_busy) begin
      ctl      = CTL_HOLD;
      stall_ev = 1'b1;
    end else if (EXE_Br_taken) begin
      ctl      = CTL_FLUSH;
      flush_ev = 1'b1;
    end else if (raw_hazard) begin
      ctl      = CTL_STALL;
      stall_ev = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:      if (mem_req && !mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready || !mem_req) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    wait_entry = (state == RUN) && (state_next == MEM_WAIT);
    wait_inc   = (state == MEM_WAIT);
  end

  sat_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (wait_entry),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  // Flag rises on the same edge the wait counter reaches the limit; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (wait_inc && (wait_cnt == WAIT_LAST)) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT ('1)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_ev),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT ('1)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_ev),
    .count (flush_cnt)
  );

  assign IF_en       = ctl.if_en;
  assign IF_ID_en    = ctl.if_id_en;
  assign IF_ID_flush = ctl.if_id_flush;
  assign ID_EX_en    = ctl.id_ex_en;
  assign ctrl_clear  = ctl.ctrl_clear;
  assign freeze      = mem_busy;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance (16-bit counters) and a no-forwarding
// instance (3-bit counters) share stimulus and are checked against an action model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst;
  logic       ID_valid;
  logic [4:0] ID_src1;
  logic [4:0] ID_src2;
  logic       ID_two_src;
  logic [4:0] EXE_dest;
  logic       EXE_MEM_R_en;
  logic       EXE_WB_en;
  logic       EXE_Br_taken;
  logic [4:0] MEM_dest;
  logic       MEM_WB_en;
  logic       mem_req;
  logic       mem_ready;

  logic        if_en_f, if_id_en_f, if_id_flush_f, id_ex_en_f, ctrl_clear_f, freeze_f, timeout_f;
  logic [15:0] stall_cnt_f, flush_cnt_f;
  logic        if_en_n, if_id_en_n, if_id_flush_n, id_ex_en_n, ctrl_clear_n, freeze_n, timeout_n;
  logic [2:0]  stall_cnt_n, flush_cnt_n;

  hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut_fwd (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_dest(EXE_dest), .EXE_MEM_R_en(EXE_MEM_R_en),
    .EXE_WB_en(EXE_WB_en), .EXE_Br_taken(EXE_Br_taken), .MEM_dest(MEM_dest),
    .MEM_WB_en(MEM_WB_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .IF_en(if_en_f), .IF_ID_en(if_id_en_f), .IF_ID_flush(if_id_flush_f), .ID_EX_en(id_ex_en_f),
    .ctrl_clear(ctrl_clear_f), .freeze(freeze_f), .mem_timeout(timeout_f),
    .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(TIMEOUT), .CNT_W(3)) dut_nofwd (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_dest(EXE_dest), .EXE_MEM_R_en(EXE_MEM_R_en),
    .EXE_WB_en(EXE_WB_en), .EXE_Br_taken(EXE_Br_taken), .MEM_dest(MEM_dest),
    .MEM_WB_en(MEM_WB_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .IF_en(if_en_n), .IF_ID_en(if_id_en_n), .IF_ID_flush(if_id_flush_n), .ID_EX_en(id_ex_en_n),
    .ctrl_clear(ctrl_clear_n), .freeze(freeze_n), .mem_timeout(timeout_n),
    .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n)
  );

  // Control bundle order: {IF_en, IF_ID_en, IF_ID_flush, ID_EX_en, ctrl_clear, freeze}
  localparam logic [5:0] C_IDLE   = 6'b110100;
  localparam logic [5:0] C_STALL  = 6'b000110;
  localparam logic [5:0] C_FLUSH  = 6'b111110;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  typedef enum int {A_IDLE, A_STALL, A_FLUSH, A_FREEZE} act_t;

  wire [5:0] ctl_f = {if_en_f, if_id_en_f, if_id_flush_f, id_ex_en_f, ctrl_clear_f, freeze_f};
  wire [5:0] ctl_n = {if_en_n, if_id_en_n, if_id_flush_n, id_ex_en_n, ctrl_clear_n, freeze_n};

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  // Model state, index 0 = forwarding instance, 1 = no-forwarding instance.
  bit m_wait  [2] = '{1'b0, 1'b0};
  int m_wcyc  [2] = '{0, 0};
  bit m_tout  [2] = '{1'b0, 1'b0};
  int m_stall [2] = '{0, 0};
  int m_flush [2] = '{0, 0};
  int cnt_max [2] = '{65535, 7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Registers that are awaiting write-back and would be read too early.
  function automatic bit model_hazard(input int k);
    logic [31:0] pend;
    logic [31:0] reads;
    pend  = '0;
    reads = '0;
    if (EXE_MEM_R_en) pend[EXE_dest] = 1'b1;
    if (k == 1) begin
      if (EXE_WB_en) pend[EXE_dest] = 1'b1;
      if (MEM_WB_en) pend[MEM_dest] = 1'b1;
    end
    pend[0]      = 1'b0;
    reads[ID_src1] = 1'b1;
    if (ID_two_src) reads[ID_src2] = 1'b1;
    return ID_valid && ((pend & reads) != 32'd0);
  endfunction

  function automatic act_t model_action(input int k);
    bit busy;
    busy = m_wait[k] ? !mem_ready : (mem_req && !mem_ready);
    if (busy) return A_FREEZE;
    if (EXE_Br_taken) return A_FLUSH;
    if (model_hazard(k)) return A_STALL;
    return A_IDLE;
  endfunction

  function automatic logic [5:0] model_ctl(input int k);
    case (model_action(k))
      A_FREEZE: return C_FREEZE;
      A_FLUSH:  return C_FLUSH;
      A_STALL:  return C_STALL;
      default:  return C_IDLE;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_wait[k]  <= 1'b0;
        m_wcyc[k]  <= 0;
        m_tout[k]  <= 1'b0;
        m_stall[k] <= 0;
        m_flush[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if ((model_action(k) == A_FREEZE || model_action(k) == A_STALL) && m_stall[k] < cnt_max[k])
          m_stall[k] <= m_stall[k] + 1;
        if (model_action(k) == A_FLUSH && m_flush[k] < cnt_max[k])
          m_flush[k] <= m_flush[k] + 1;
        if (m_wait[k]) begin
          m_wcyc[k] <= m_wcyc[k] + 1;
          if (m_wcyc[k] + 1 >= TIMEOUT) m_tout[k] <= 1'b1;
          m_wait[k] <= mem_req && !mem_ready;
        end else if (mem_req && !mem_ready) begin
          m_wait[k] <= 1'b1;
          m_wcyc[k] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("ctl_fwd",     32'(ctl_f),       32'(model_ctl(0)));
      check("ctl_nofwd",   32'(ctl_n),       32'(model_ctl(1)));
      check("tout_fwd",    32'(timeout_f),   32'(m_tout[0]));
      check("tout_nofwd",  32'(timeout_n),   32'(m_tout[1]));
      check("stall_fwd",   32'(stall_cnt_f), 32'(m_stall[0]));
      check("stall_nofwd", 32'(stall_cnt_n), 32'(m_stall[1]));
      check("flush_fwd",   32'(flush_cnt_f), 32'(m_flush[0]));
      check("flush_nofwd", 32'(flush_cnt_n), 32'(m_flush[1]));
    end
  end

  task automatic idle();
    ID_valid = 1'b0; ID_src1 = 5'd0; ID_src2 = 5'd0; ID_two_src = 1'b0;
    EXE_dest = 5'd0; EXE_MEM_R_en = 1'b0; EXE_WB_en = 1'b0; EXE_Br_taken = 1'b0;
    MEM_dest = 5'd0; MEM_WB_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    idle();
    rst = 1'b0;
    next();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    cmp_on = 1'b1;

    @(negedge clk);
    check("reset_ctl", 32'(ctl_f), 32'(C_IDLE));
    check("reset_stall", 32'(stall_cnt_f), 32'd0);

    // Load-use: one stall cycle, then the bubble in ID/EX clears it.
    next();
    ID_valid = 1'b1; EXE_MEM_R_en = 1'b1; EXE_dest = 5'd5; ID_src1 = 5'd5;
    @(negedge clk);
    check("lu_stall_ctl", 32'(ctl_f), 32'(C_STALL));
    next();
    EXE_MEM_R_en = 1'b0;
    @(negedge clk);
    check("lu_release_ctl", 32'(ctl_f), 32'(C_IDLE));
    check("lu_stall_cnt", 32'(stall_cnt_f), 32'd1);

    // Register zero never matches; the no-forwarding instance stalls on plain RAW.
    do_reset();
    ID_valid = 1'b1; EXE_MEM_R_en = 1'b1; EXE_dest = 5'd0; ID_src1 = 5'd0;
    @(negedge clk);
    check("r0_fwd", 32'(ctl_f), 32'(C_IDLE));
    check("r0_nofwd", 32'(ctl_n), 32'(C_IDLE));
    next();
    EXE_MEM_R_en = 1'b0; ID_src1 = 5'd3; ID_two_src = 1'b1; ID_src2 = 5'd7;
    MEM_WB_en = 1'b1; MEM_dest = 5'd7;
    @(negedge clk);
    check("memraw_fwd", 32'(ctl_f), 32'(C_IDLE));
    check("memraw_nofwd", 32'(ctl_n), 32'(C_STALL));
    next();
    ID_two_src = 1'b0;
    @(negedge clk);
    check("one_src_nofwd", 32'(ctl_n), 32'(C_IDLE));
    next();
    ID_two_src = 1'b1; MEM_dest = 5'd0; ID_src2 = 5'd0;
    @(negedge clk);
    check("memr0_nofwd", 32'(ctl_n), 32'(C_IDLE));
    next();
    MEM_WB_en = 1'b0; EXE_WB_en = 1'b1; EXE_dest = 5'd3;
    @(negedge clk);
    check("exeraw_fwd", 32'(ctl_f), 32'(C_IDLE));
    check("exeraw_nofwd", 32'(ctl_n), 32'(C_STALL));
    next();
    idle();
    @(negedge clk);
    check("raw_stall_nofwd", 32'(stall_cnt_n), 32'd2);
    check("raw_stall_fwd", 32'(stall_cnt_f), 32'd0);

    // Branch wins over a load-use hazard in the same cycle.
    do_reset();
    ID_valid = 1'b1; EXE_MEM_R_en = 1'b1; EXE_dest = 5'd5; ID_src1 = 5'd5; EXE_Br_taken = 1'b1;
    @(negedge clk);
    check("br_hz_ctl", 32'(ctl_f), 32'(C_FLUSH));
    next();
    idle();
    @(negedge clk);
    check("br_flush_cnt", 32'(flush_cnt_f), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt_f), 32'd0);

    // Three not-ready cycles freeze; a pending branch applies on release.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; EXE_Br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_freeze_ctl", 32'(ctl_f), 32'(C_FREEZE));
      next();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("mw_release_ctl", 32'(ctl_f), 32'(C_FLUSH));
    next();
    idle();
    @(negedge clk);
    check("mw_stall_cnt", 32'(stall_cnt_f), 32'd3);
    check("mw_flush_cnt", 32'(flush_cnt_f), 32'd1);

    // Timeout: cycle 1 enters the wait, cycle 16 is the 15th MEM_WAIT cycle.
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("to_flag", 32'(timeout_f), (i >= 17) ? 32'd1 : 32'd0);
      next();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("to_release_ctl", 32'(ctl_f), 32'(C_IDLE));
    check("to_sticky", 32'(timeout_f), 32'd1);
    next();
    idle();
    @(negedge clk);
    check("to_sticky_idle", 32'(timeout_f), 32'd1);
    check("to_stall_fwd", 32'(stall_cnt_f), 32'd20);
    check("to_stall_sat", 32'(stall_cnt_n), 32'd7);

    // Reset in the middle of a wait returns to RUN at once.
    next();
    mem_req = 1'b1; mem_ready = 1'b0;
    next();
    next();
    #2;
    mem_req = 1'b0;
    rst     = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(ctl_f), 32'(C_IDLE));
    check("mid_rst_tout", 32'(timeout_f), 32'd0);
    check("mid_rst_stall", 32'(stall_cnt_f), 32'd0);
    check("mid_rst_flush", 32'(flush_cnt_f), 32'd0);
    next();
    rst = 1'b1;

    // Nine flushes: the 3-bit counter sticks at all-ones.
    EXE_Br_taken = 1'b1;
    repeat (9) next();
    EXE_Br_taken = 1'b0;
    @(negedge clk);
    check("flush9_fwd", 32'(flush_cnt_f), 32'd9);
    check("flush9_sat", 32'(flush_cnt_n), 32'd7);

    next();
    next();
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and freeze controller for the 5-stage MIPS core. It reads the ID-stage operand fields and the ID/EX register outputs, and drives the enable and bubble controls of the IF, IF/ID and ID/EX stages. It handles three cases: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits. It also keeps a wait-timeout flag and saturating stall/flush performance counters.

## Interface
Parameters:
- FWD_EN, 1: forwarding present. With 1, only load-use hazards stall. With 0, any RAW hazard against EXE or MEM stalls.
- MEM_TIMEOUT, 15: number of MEM_WAIT cycles before mem_timeout sets.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ID_valid  in  1  the ID stage holds a real instruction.
- ID_src1, ID_src2  in  5  source register numbers decoded in ID.
- ID_two_src  in  1  the instruction reads ID_src2.
- EXE_dest  in  5  destination field from the ID/EX register outputs.
- EXE_MEM_R_en, EXE_WB_en  in  1  control bits from the ID/EX register outputs.
- EXE_Br_taken  in  1  branch resolved taken in EXE.
- MEM_dest  in  5  destination in the EX/MEM register.
- MEM_WB_en  in  1  write-back enable in the EX/MEM register.
- mem_req  in  1  the MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- IF_en  out  1  PC and instruction fetch advance.
- IF_ID_en  out  1  the IF/ID register loads.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_en  out  1  ID/EX register enable.
- ctrl_clear  out  1  the ID stage forces EXE_cmd, MEM_R_en, MEM_W_en, WB_en and Br_taken to 0 (a bubble).
- freeze  out  1  the EX/MEM and MEM/WB registers hold.
- mem_timeout  out  1  sticky wait-timeout error.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: memory access in progress.
- Transitions:
  - RUN to MEM_WAIT when mem_req=1 and mem_ready=0.
  - MEM_WAIT to RUN on mem_ready=1.
  - mem_req dropping while in MEM_WAIT also returns to RUN.
- In MEM_WAIT:
  - freeze=~mem_ready.
  - While freeze=1, IF_en, IF_ID_en and ID_EX_en are 0, and ctrl_clear and IF_ID_flush are 0.
  - On the completion cycle, the outputs are computed exactly as in RUN.
- Load-use hazard:
  - Condition: ID_valid, EXE_MEM_R_en, EXE_dest≠0, and EXE_dest matches ID_src1, or matches ID_src2 when ID_two_src=1.
  - When FWD_EN=0, the hazard also asserts when EXE_WB_en is set with a match on EXE_dest, or MEM_WB_en is set with a match on MEM_dest. Register 0 never matches.
  - Response: IF_en=0, IF_ID_en=0, ID_EX_en=1, ctrl_clear=1.
- Taken branch (EXE_Br_taken=1): IF_en=1, IF_ID_en=1, IF_ID_flush=1, ID_EX_en=1, ctrl_clear=1.
- Priority when events coincide: freeze, then branch, then hazard. A branch flush discards a hazard in the wrong-path ID instruction.
- Idle (no event): all enables are 1, and flush and clear are 0.
- Wait counter:
  - Clears on entry to MEM_WAIT.
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - mem_timeout sets when the counter reaches MEM_TIMEOUT, and clears only on reset. The FSM keeps waiting after a timeout.
- stall_cnt increments on each cycle with freeze=1 or a load-use stall.
- flush_cnt increments on each taken-branch flush cycle.
- Both counters saturate at all-ones.

## Timing
- All control outputs are combinational from the current state and inputs, with zero-cycle latency. Registered elements are the state, wait counter, mem_timeout and the performance counters.
- A load-use stall lasts exactly 1 cycle. On the next cycle ID/EX holds a bubble, so EXE_MEM_R_en=0 and the hazard self-clears.
- A taken branch costs 2 cycles: the IF/ID and ID/EX contents are replaced.
- A branch that coincides with MEM_WAIT is held in ID/EX by the freeze and is applied on the release cycle.
- Reset, including assertion in the middle of MEM_WAIT:
  - State returns to RUN; the wait counter, mem_timeout, stall_cnt and flush_cnt go to 0.
  - Outputs follow from those register values and the live inputs. With idle inputs: IF_en=IF_ID_en=ID_EX_en=1, others 0.

## Structure
- Shared package, hazard_pkg, holds:
  - the FSM state typedef, {RUN, MEM_WAIT};
  - the REG_ZERO constant (5'd0);
  - the NOP instruction constant used for IF_ID_flush.
- One natural sub-module, sat_counter, is instantiated for stall_cnt, flush_cnt and the wait counter. Parameters: width, saturation limit. Ports: inc, async active-low reset.

## Test plan
- Load-use: EXE_MEM_R_en=1, EXE_dest=5, ID_src1=5, ID_valid=1 → one cycle with IF_en=0, IF_ID_en=0, ctrl_clear=1; stall_cnt=1.
- Register zero: EXE_dest=0, ID_src1=0 with load → no stall. With FWD_EN=0, MEM_WB_en=1, MEM_dest=7, ID_two_src=1, ID_src2=7 → stall.
- Branch plus hazard in the same cycle → IF_ID_flush=1, IF_en=1, ctrl_clear=1, no stall; flush_cnt=1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles → freeze=1 for 3 cycles, release on cycle 4; stall_cnt=3.
- Timeout: mem_ready held low for 20 cycles → mem_timeout rises after the 15th MEM_WAIT cycle and stays 1 after release.
- Reset asserted mid-MEM_WAIT → immediate return to RUN; all counters 0; freeze=0.
